// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: serves 32-bit loads/stores as two half-word phases on a 16-bit async SRAM.
// Optional MEM_BASE_OFFSET_EN: subtracts BASE_ADDR from ALU_res before word indexing.
module sram_mem_ctrl #(
  parameter int          WAIT_CYCLES = 3,
  parameter int          SRAM_AW     = 18,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R,
  input  logic               MEM_W,
  input  logic [31:0]        ALU_res,
  input  logic [31:0]        val_rm,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [SRAM_AW-2:0] idx;
  logic [31:0]        val_lat;
  logic [15:0]        data_lo;
  logic [31:0]        addr;
  logic               phase_end;
  logic               dq_en;
  logic [15:0]        dq_out;
  logic               unused_bits;

`ifdef MEM_BASE_OFFSET_EN
  assign addr = ALU_res - BASE_ADDR;
`else
  assign addr = ALU_res;
`endif

  // Byte-lane and out-of-range address bits are deliberately ignored.
  assign unused_bits = ^{addr[31:SRAM_AW+1], addr[1:0], BASE_ADDR};

  assign phase_end = (cnt == 4'(WAIT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MEM_W) state_nxt = WR_LO;
               else if (MEM_R) state_nxt = RD_LO;
      RD_LO:   if (phase_end) state_nxt = RD_HI;
      RD_HI:   if (phase_end) state_nxt = DONE;
      WR_LO:   if (phase_end) state_nxt = WR_HI;
      WR_HI:   if (phase_end) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request operands are captured once in IDLE and never re-sampled mid-access.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      idx       <= '0;
      val_lat   <= 32'd0;
      data_lo   <= 16'd0;
      read_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (MEM_R || MEM_W) begin
            idx     <= addr[SRAM_AW:2];
            val_lat <= val_rm;
          end
        end
        RD_LO, RD_HI, WR_LO, WR_HI: cnt <= phase_end ? 4'd0 : cnt + 4'd1;
        default: cnt <= 4'd0;
      endcase
      if (state == RD_LO && phase_end) data_lo   <= SRAM_DQ;
      if (state == RD_HI && phase_end) read_data <= {SRAM_DQ, data_lo};
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_en     = 1'b0;
    dq_out    = 16'd0;
    case (state)
      IDLE:  ready = ~(MEM_R | MEM_W);
      RD_LO: begin
        SRAM_OE_N = 1'b0;
        SRAM_ADDR = {idx, 1'b0};
      end
      RD_HI: begin
        SRAM_OE_N = 1'b0;
        SRAM_ADDR = {idx, 1'b1};
      end
      WR_LO: begin
        SRAM_WE_N = 1'b0;
        SRAM_ADDR = {idx, 1'b0};
        dq_en     = 1'b1;
        dq_out    = val_lat[15:0];
      end
      WR_HI: begin
        SRAM_WE_N = 1'b0;
        SRAM_ADDR = {idx, 1'b1};
        dq_en     = 1'b1;
        dq_out    = val_lat[31:16];
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign SRAM_DQ = dq_en ? dq_out : 16'bz;

endmodule
